fifo_short: RTL and testbench



---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifo_short_if.sv | 35 +++
 rtl/fifo_short_mem.sv | 31 +++
 rtl/fifo_short.sv | 80 ++++++++
 tb/tb_fifo_short.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the short packet-datapath FIFO: word width,
// depth and the word type used by the interface, memory and top level.
package fifo_pkg;

    localparam int FIFO_WIDTH      = 36;
    localparam int FIFO_DEPTH_LOG2 = 4;

    typedef logic [FIFO_WIDTH-1:0] fifo_word_t;

endpackage

// File: rtl/fifo_short_if.sv
// Ready/ready handshake bundle for fifo_short. The slave modport is the
// FIFO's view of the bundle. The master modport is the surrounding
// producer/consumer's view.
interface fifo_short_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
) ();

    logic [WIDTH-1:0] datain;
    logic             src_rdy_i;
    logic             dst_rdy_o;
    logic [WIDTH-1:0] dataout;
    logic             src_rdy_o;
    logic             dst_rdy_i;

    modport slave (
        input  datain,
        input  src_rdy_i,
        output dst_rdy_o,
        output dataout,
        output src_rdy_o,
        input  dst_rdy_i
    );

    modport master (
        output datain,
        output src_rdy_i,
        input  dst_rdy_o,
        input  dataout,
        input  src_rdy_o,
        output dst_rdy_i
    );

endinterface

// File: rtl/fifo_short_mem.sv
// Storage array for fifo_short: one synchronous write port and one
// asynchronous read port. The array is deliberately never reset, so a
// flush only needs to touch the pointers in the parent.
module fifo_short_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH      = FIFO_WIDTH,
    parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
    input  logic                  clock,
    input  logic                  i_wrEn,
    input  logic [DEPTH_LOG2-1:0] i_wrAddr,
    input  logic [WIDTH-1:0]      i_wrData,
    input  logic [DEPTH_LOG2-1:0] i_rdAddr,
    output logic [WIDTH-1:0]      o_rdData
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Store the incoming word at the write address on an accepted write
    always_ff @(posedge clock) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/fifo_short.sv
// Sixteen-entry first-word-fall-through FIFO with ready/ready flow control.
// Both ready outputs come only from the occupancy register, so no
// combinational path runs from either input handshake to the outputs.
// Optional feature macro: FIFO_SHORT_STATUS_EN adds the space/occupied
// status outputs.
module fifo_short
    import fifo_pkg::*;
#(
    parameter int WIDTH      = FIFO_WIDTH,
    parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clear,
    fifo_short_if.slave     bus
`ifdef FIFO_SHORT_STATUS_EN
    ,
    output logic [DEPTH_LOG2:0] space,
    output logic [DEPTH_LOG2:0] occupied
`endif
);

    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);

    logic [DEPTH_LOG2-1:0] r_wrPtr;
    logic [DEPTH_LOG2-1:0] r_rdPtr;
    logic [DEPTH_LOG2:0]   r_count;

    logic w_flush;
    logic w_write;
    logic w_read;

    // A flush wins over any handshake in the same cycle, so both
    // transfers are suppressed while reset or clear is high.
    assign w_flush = reset | clear;
    assign w_write = bus.src_rdy_i & bus.dst_rdy_o & ~w_flush;
    assign w_read  = bus.src_rdy_o & bus.dst_rdy_i & ~w_flush;

    assign bus.dst_rdy_o = (r_count != FULL_COUNT);
    assign bus.src_rdy_o = (r_count != '0);

`ifdef FIFO_SHORT_STATUS_EN
    assign space    = FULL_COUNT - r_count;
    assign occupied = r_count;
`endif

    fifo_short_mem #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clock    (clock),
        .i_wrEn   (w_write),
        .i_wrAddr (r_wrPtr),
        .i_wrData (bus.datain),
        .i_rdAddr (r_rdPtr),
        .o_rdData (bus.dataout)
    );

    // Advance the pointers and track occupancy. A simultaneous read and write leaves the count unchanged.
    always_ff @(posedge clock) begin
        if (w_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_write) begin
                r_wrPtr <= r_wrPtr + (DEPTH_LOG2)'(1);
            end
            if (w_read) begin
                r_rdPtr <= r_rdPtr + (DEPTH_LOG2)'(1);
            end
            case ({w_write, w_read})
                2'b10:   r_count <= r_count + (DEPTH_LOG2+1)'(1);
                2'b01:   r_count <= r_count - (DEPTH_LOG2+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_short.sv
// Self-checking bench for fifo_short: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_fifo_short;
    import fifo_pkg::*;

    logic clock;
    logic reset;
    logic clear;

    int total;
    int bad;

    fifo_word_t model[$];

    fifo_short_if bus ();

`ifdef FIFO_SHORT_STATUS_EN
    logic [FIFO_DEPTH_LOG2:0] space;
    logic [FIFO_DEPTH_LOG2:0] occupied;
`endif

    fifo_short dut (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .bus   (bus)
`ifdef FIFO_SHORT_STATUS_EN
        ,
        .space    (space),
        .occupied (occupied)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // The model follows the handshake rules directly. A write is taken while
    // the queue has room, and a read is taken while the queue is non-empty.
    // Room is judged before any same-cycle pop. A flush empties the queue.
    always @(posedge clock) begin
        bit wr;
        bit rd;
        wr = bus.src_rdy_i && (model.size() < 16);
        rd = bus.dst_rdy_i && (model.size() > 0);
        if (reset || clear) begin
            model.delete();
        end else begin
            if (rd) void'(model.pop_front());
            if (wr) model.push_back(bus.datain);
        end
    end

    // Compare every visible output against the model midway through each cycle.
    always @(negedge clock) begin
        checkOutput("dst_rdy_o", 64'(bus.dst_rdy_o), 64'(model.size() != 16));
        checkOutput("src_rdy_o", 64'(bus.src_rdy_o), 64'(model.size() != 0));
        if (model.size() > 0) begin
            checkOutput("dataout", 64'(bus.dataout), 64'(model[0]));
        end
`ifdef FIFO_SHORT_STATUS_EN
        checkOutput("occupied", 64'(occupied), 64'(model.size()));
        checkOutput("space", 64'(space), 64'(16 - model.size()));
`endif
    end

    task automatic applyStimulus(input bit srcRdy, input fifo_word_t data, input bit dstRdy,
                                 input bit clr, input bit rst);
        bus.src_rdy_i = srcRdy;
        bus.datain    = data;
        bus.dst_rdy_i = dstRdy;
        clear         = clr;
        reset         = rst;
        @(posedge clock);
        #1;
    endtask

    function automatic fifo_word_t randWord();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[FIFO_WIDTH-1:0];
    endfunction

    initial begin
        total = 0;
        bad   = 0;

        // Reset held for two cycles while the producer offers a word
        applyStimulus(1'b1, 36'h5_5555_5555, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 36'h5_5555_5555, 1'b0, 1'b0, 1'b1);
        checkOutput("reset_dst_rdy", 64'(bus.dst_rdy_o), 64'd1);
        checkOutput("reset_src_rdy", 64'(bus.src_rdy_o), 64'd0);
        checkOutput("reset_model_size", 64'(model.size()), 64'd0);

        // Single word written with the consumer stalled, then popped
        applyStimulus(1'b1, 36'h0_DEAD_BEEF, 1'b0, 1'b0, 1'b0);
        checkOutput("single_src_rdy", 64'(bus.src_rdy_o), 64'd1);
        checkOutput("single_dataout", 64'(bus.dataout), 64'h0_DEAD_BEEF);
        checkOutput("single_model_head", 64'(model[0]), 64'h0_DEAD_BEEF);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("single_popped", 64'(bus.src_rdy_o), 64'd0);

        // Fill to sixteen, try a seventeenth, then drain in order
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, fifo_word_t'(i), 1'b0, 1'b0, 1'b0);
        end
        checkOutput("fill_full", 64'(bus.dst_rdy_o), 64'd0);
        checkOutput("fill_model_size", 64'(model.size()), 64'd16);
        applyStimulus(1'b1, 36'hF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        checkOutput("fill_17th_blocked", 64'(bus.dst_rdy_o), 64'd0);
        checkOutput("fill_17th_model", 64'(model.size()), 64'd16);
        for (int i = 0; i < 16; i++) begin
            checkOutput("drain_order", 64'(bus.dataout), 64'(i));
            applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("drain_empty", 64'(bus.src_rdy_o), 64'd0);

        // Streaming: output follows input one cycle later with one word held
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, fifo_word_t'(i + 1000), 1'b1, 1'b0, 1'b0);
            checkOutput("stream_dataout", 64'(bus.dataout), 64'(i + 1000));
            checkOutput("stream_model_size", 64'(model.size()), 64'd1);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("stream_drained", 64'(bus.src_rdy_o), 64'd0);

        // Full with a simultaneous read: pop happens, write is refused
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, fifo_word_t'(i + 100), 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 36'hABC, 1'b1, 1'b0, 1'b0);
        checkOutput("fullrd_dst_rdy", 64'(bus.dst_rdy_o), 64'd1);
        checkOutput("fullrd_dataout", 64'(bus.dataout), 64'd101);
        checkOutput("fullrd_model_size", 64'(model.size()), 64'd15);
        for (int k = 0; k < 40 && model.size() > 0; k++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("fullrd_drained", 64'(bus.src_rdy_o), 64'd0);

        // Clear mid-operation alongside a write
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, fifo_word_t'(i + 200), 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 36'h777, 1'b0, 1'b1, 1'b0);
        checkOutput("clear_src_rdy", 64'(bus.src_rdy_o), 64'd0);
        checkOutput("clear_dst_rdy", 64'(bus.dst_rdy_o), 64'd1);
        applyStimulus(1'b1, 36'h123, 1'b0, 1'b0, 1'b0);
        checkOutput("clear_readback", 64'(bus.dataout), 64'h123);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic with occasional flushes, biased to hit full and empty
        for (int i = 0; i < 3000; i++) begin
            int phase;
            bit s;
            bit d;
            phase = (i / 200) % 3;
            case (phase)
                0:       begin s = ($urandom_range(0, 3) != 0); d = ($urandom_range(0, 3) == 0); end
                1:       begin s = ($urandom_range(0, 3) == 0); d = ($urandom_range(0, 3) != 0); end
                default: begin s = $urandom_range(0, 1) != 0;   d = $urandom_range(0, 1) != 0;   end
            endcase
            applyStimulus(s, randWord(), d,
                          $urandom_range(0, 99) == 0, $urandom_range(0, 199) == 0);
        end

        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
